// File: rtl/wb_simple_master_pkg.sv
// Shared types and helpers for the wb_simple_master pipelined Wishbone initiator.
package wb_simple_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } t_wbm_state;

    localparam int C_CMD_ADDR_WIDTH = 32;
    localparam int C_CMD_DATA_WIDTH = 32;
    localparam int C_CMD_SEL_WIDTH  = C_CMD_DATA_WIDTH / 8;

    // One command as seen on the valid/ready stream, at the default bus widths.
    typedef struct packed {
        logic                        we;
        logic [C_CMD_ADDR_WIDTH-1:0] adr;
        logic [C_CMD_DATA_WIDTH-1:0] dat;
        logic [C_CMD_SEL_WIDTH-1:0]  sel;
    } t_wbm_cmd;

    // Number of abort responses owed when a timeout hits: every retired
    // request plus the one still being strobed.
    function automatic logic [4:0] f_drain_count(input logic [3:0] outstanding,
                                                 input logic       stb);
        return {1'b0, outstanding} + {4'b0000, stb};
    endfunction

endpackage

// File: rtl/wbm_txn_tracker.sv
// Book-keeping for in-flight Wishbone transactions: outstanding count,
// read/write FIFO, idle timeout and abort drain count.
module wbm_txn_tracker
    import wb_simple_master_pkg::*;
#(
    parameter int g_max_outstanding = 4,
    parameter int g_timeout         = 1023
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       retire,
    input  logic       we_retire,
    input  logic       rsp_event,
    input  logic       activity,
    input  logic       active,
    input  logic       drain,
    input  logic       stb,
    output logic [3:0] outstanding,
    output logic [3:0] outstanding_nxt,
    output logic       rsp_we,
    output logic       timeout_hit,
    output logic       drain_last
);

    localparam int PW = (g_max_outstanding > 1) ? $clog2(g_max_outstanding) : 1;
    localparam int TW = $clog2(g_timeout + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(g_max_outstanding - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(g_timeout - 1);

    logic [g_max_outstanding-1:0] we_fifo;
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [3:0]                   count;
    logic [TW-1:0]                tmo_cnt;
    logic [4:0]                   drain_cnt;

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign outstanding     = count;
    assign outstanding_nxt = count + {3'b000, retire} - {3'b000, rsp_event};
    // An ack in the same cycle as the first retire belongs to the retiring request.
    assign rsp_we          = (count == 4'd0) ? we_retire : we_fifo[rd_ptr];
    assign timeout_hit     = active & ~activity & (tmo_cnt == '0) & (stb | (count != 4'd0));
    assign drain_last      = drain & (drain_cnt == 5'd1);

    // Outstanding counter and we-bit FIFO; a timeout abort discards everything in flight.
    always_ff @(posedge clk_sys) begin
        if (rst || timeout_hit) begin
            count   <= 4'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            we_fifo <= '0;
        end else begin
            count <= outstanding_nxt;
            if (retire) begin
                we_fifo[wr_ptr] <= we_retire;
                wr_ptr          <= f_next_ptr(wr_ptr);
            end
            if (rsp_event) begin
                rd_ptr <= f_next_ptr(rd_ptr);
            end
        end
    end

    // Idle timer: down-counter reloaded on any bus or command activity.
    always_ff @(posedge clk_sys) begin
        if (rst || !active || activity) begin
            tmo_cnt <= TMO_LOAD;
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    // Abort drain counter: loaded at the timeout, one response per DRAIN cycle.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            drain_cnt <= 5'd0;
        end else if (timeout_hit) begin
            drain_cnt <= f_drain_count(count, stb);
        end else if (drain && (drain_cnt != 5'd0)) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/wb_simple_master.sv
// Pipelined Wishbone B4 initiator: converts a valid/ready command stream into
// Wishbone cycles and returns one in-order response per command.
//
//   state  | meaning
//   IDLE   | no cycle open, nothing in flight
//   ACTIVE | cycle open, requests being strobed and/or awaiting ack
//   DRAIN  | timeout abort: bus released, error responses owed being emitted
module wb_simple_master
    import wb_simple_master_pkg::*;
#(
    parameter int g_addr_width      = 32,
    parameter int g_data_width      = 32,
    parameter int g_max_outstanding = 4,
    parameter int g_timeout         = 1023
) (
    input  logic                      clk_sys_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [g_addr_width-1:0]   cmd_adr_i,
    input  logic [g_data_width-1:0]   cmd_dat_i,
    input  logic [g_data_width/8-1:0] cmd_sel_i,
    output logic                      rsp_valid_o,
    output logic [g_data_width-1:0]   rsp_dat_o,
    output logic                      rsp_err_o,
    output logic                      rsp_tmo_o,
    output logic                      busy_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [g_addr_width-1:0]   wb_adr_o,
    output logic [g_data_width-1:0]   wb_dat_o,
    output logic [g_data_width/8-1:0] wb_sel_o,
    input  logic [g_data_width-1:0]   wb_dat_i,
    input  logic                      wb_ack_i,
    input  logic                      wb_err_i,
    input  logic                      wb_stall_i
);

    t_wbm_state state;
    t_wbm_state state_nxt;

    logic       accept;
    logic       retire;
    logic       rsp_event;
    logic       activity;
    logic       active;
    logic       drain;
    logic       timeout_hit;
    logic       drain_last;
    logic       rsp_we;
    logic [3:0] outstanding;
    logic [3:0] outstanding_nxt;
    logic [4:0] in_flight;

    assign in_flight   = {1'b0, outstanding} + {4'b0000, wb_stb_o};
    // Credit only what is already known; an ack arriving this cycle frees a slot next cycle.
    assign cmd_ready_o = ~drain & (~wb_stb_o | ~wb_stall_i) &
                         (in_flight < 5'(g_max_outstanding));
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign retire      = wb_stb_o & ~wb_stall_i;
    assign rsp_event   = active & (wb_ack_i | wb_err_i) & ((outstanding != 4'd0) | retire);
    assign activity    = accept | retire | wb_ack_i | wb_err_i;

    wbm_txn_tracker #(
        .g_max_outstanding (g_max_outstanding),
        .g_timeout         (g_timeout)
    ) u_tracker (
        .clk_sys         (clk_sys_i),
        .rst             (rst_i),
        .retire          (retire),
        .we_retire       (wb_we_o),
        .rsp_event       (rsp_event),
        .activity        (activity),
        .active          (active),
        .drain           (drain),
        .stb             (wb_stb_o),
        .outstanding     (outstanding),
        .outstanding_nxt (outstanding_nxt),
        .rsp_we          (rsp_we),
        .timeout_hit     (timeout_hit),
        .drain_last      (drain_last)
    );

    // State register.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (timeout_hit) begin
                    state_nxt = DRAIN;
                end else if (!wb_stb_o && (outstanding == 4'd0) && !accept) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (drain_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State decode.
    always_comb begin
        active = 1'b0;
        drain  = 1'b0;
        busy_o = 1'b0;
        case (state)
            ACTIVE: begin
                active = 1'b1;
                busy_o = 1'b1;
            end
            DRAIN: begin
                drain  = 1'b1;
                busy_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Wishbone request registers; cyc stays up while anything is strobed or unacknowledged.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
        end else if (timeout_hit) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
        end else begin
            if (accept) begin
                wb_stb_o <= 1'b1;
                wb_we_o  <= cmd_we_i;
                wb_adr_o <= cmd_adr_i;
                wb_dat_o <= cmd_dat_i;
                wb_sel_o <= cmd_sel_i;
            end else if (retire) begin
                wb_stb_o <= 1'b0;
            end
            wb_cyc_o <= accept | (wb_stb_o & ~retire) | (outstanding_nxt != 4'd0);
        end
    end

    // Response register: one pulse per ack/err, or per owed request while draining.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_tmo_o   <= 1'b0;
            rsp_dat_o   <= '0;
        end else begin
            rsp_valid_o <= rsp_event | drain;
            rsp_err_o   <= drain | (rsp_event & wb_err_i);
            rsp_tmo_o   <= drain;
            rsp_dat_o   <= (rsp_event && !rsp_we && wb_ack_i && !wb_err_i) ? wb_dat_i : '0;
        end
    end

endmodule

// File: tb/tb_wb_simple_master.sv
// Bench for wb_simple_master: a scripted register-file slave (stall, withheld
// ack, error and stray-ack injection) plus an in-order response scoreboard.
module tb_wb_simple_master;
    import wb_simple_master_pkg::*;

    localparam int TMO = 16;

    logic        clk_sys = 1'b0;
    logic        rst     = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we  = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_tmo;
    logic        busy;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_m;
    logic [3:0]  wb_sel;
    logic [31:0] s_dat;
    logic        s_ack, s_err;
    logic        wb_stall;

    always #5 clk_sys = ~clk_sys;

    wb_simple_master #(
        .g_addr_width      (32),
        .g_data_width      (32),
        .g_max_outstanding (4),
        .g_timeout         (TMO)
    ) dut (
        .clk_sys_i   (clk_sys),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_dat_o   (rsp_dat),
        .rsp_err_o   (rsp_err),
        .rsp_tmo_o   (rsp_tmo),
        .busy_o      (busy),
        .wb_cyc_o    (wb_cyc),
        .wb_stb_o    (wb_stb),
        .wb_we_o     (wb_we),
        .wb_adr_o    (wb_adr),
        .wb_dat_o    (wb_dat_m),
        .wb_sel_o    (wb_sel),
        .wb_dat_i    (s_dat),
        .wb_ack_i    (s_ack),
        .wb_err_i    (s_err),
        .wb_stall_i  (wb_stall)
    );

    typedef struct packed {
        logic        err;
        logic        tmo;
        logic [31:0] dat;
    } t_exp;

    t_exp exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   rsp_seen = 0;
    int   cyc_rises = 0;
    logic cyc_prev = 1'b0;

    // Slave scripting knobs (written by stimulus) and slave state (written by slave).
    int          stall_at   = -1;
    int          err_at     = -1;
    bit          withhold   = 1'b0;
    int          stray_req  = 0;
    int          stray_done = 0;
    int          ret_total  = 0;
    int          st_cnt     = 0;
    logic [31:0] mem [0:15];
    logic [31:0] hold_adr   = '0;
    logic [31:0] hold_dat   = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
        end
    endtask

    assign wb_stall = wb_stb && (ret_total == stall_at) && (st_cnt < 5);

    // Slave: registered ack/err one cycle after each retire, 16-word register file.
    always @(posedge clk_sys) begin
        if (rst) begin
            s_ack     <= 1'b0;
            s_err     <= 1'b0;
            s_dat     <= '0;
            ret_total <= 0;
            st_cnt    <= 0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            s_dat <= '0;
            if (wb_stall) st_cnt <= st_cnt + 1;
            if (wb_cyc && wb_stb && !wb_stall) begin
                ret_total <= ret_total + 1;
                if (wb_we) begin
                    for (int b = 0; b < 4; b++)
                        if (wb_sel[b]) mem[wb_adr[5:2]][8*b +: 8] <= wb_dat_m[8*b +: 8];
                end else begin
                    s_dat <= mem[wb_adr[5:2]];
                end
                if (!withhold) begin
                    if (ret_total == err_at) s_err <= 1'b1;
                    else                     s_ack <= 1'b1;
                end
            end else if (stray_req != stray_done) begin
                s_ack      <= 1'b1;
                stray_done <= stray_done + 1;
            end
        end
    end

    // Monitor: pops the expected response for every rsp pulse; watches stalled requests.
    always @(negedge clk_sys) begin
        t_exp e;
        cyc_prev <= wb_cyc;
        if (wb_cyc && !cyc_prev) cyc_rises <= cyc_rises + 1;
        if (!rst && rsp_valid) begin
            rsp_seen <= rsp_seen + 1;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp", 64'({rsp_err, rsp_tmo, rsp_dat}), 64'({e.err, e.tmo, e.dat}));
            end
        end
        if (!rst && wb_stall)
            check("stall_hold", {wb_stb, wb_adr[30:0], wb_dat_m}, {1'b1, hold_adr[30:0], hold_dat});
    end

    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input t_exp e, output int waited);
        t_wbm_cmd c;
        c = '{we: we, adr: adr, dat: dat, sel: sel};
        cmd_valid = 1'b1;
        cmd_we    = c.we;
        cmd_adr   = c.adr;
        cmd_dat   = c.dat;
        cmd_sel   = c.sel;
        waited    = 0;
        @(negedge clk_sys);
        while (!cmd_ready && waited < 100) begin
            waited++;
            @(negedge clk_sys);
        end
        if (!cmd_ready) check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
        else            exp_q.push_back(e);
        @(posedge clk_sys);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(posedge clk_sys); #1;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(posedge clk_sys); #1;
            n++;
        end
        check(name, 64'({busy, 31'(exp_q.size())}), 64'd0);
    endtask

    initial begin
        logic [31:0] tbl [0:5];
        int          w;
        int          snap;
        int          n;
        tbl[0] = 32'h0000_1001; tbl[1] = 32'h0000_2002; tbl[2] = 32'h0000_3003;
        tbl[3] = 32'h0000_4004; tbl[4] = 32'h0000_5005; tbl[5] = 32'h0000_6006;

        repeat (3) @(posedge clk_sys);
        #1 rst = 1'b0;

        // 1: reset in the middle of a burst
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3C; cmd_dat = 32'h1234_5678; cmd_sel = 4'hF;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        rst = 1'b1; cmd_valid = 1'b0;
        @(posedge clk_sys); #1;
        check("rst_ctl",     64'({wb_cyc, wb_stb, wb_we, busy, wb_sel}), 64'd0);
        check("rst_adr",     64'(wb_adr), 64'd0);
        check("rst_dat",     64'(wb_dat_m), 64'd0);
        check("rst_rsp",     64'({rsp_valid, rsp_err, rsp_tmo}), 64'd0);
        check("rst_rsp_dat", 64'(rsp_dat), 64'd0);
        repeat (2) @(posedge clk_sys);
        #1 rst = 1'b0;
        snap = rsp_seen;
        repeat (6) @(posedge clk_sys);
        #1;
        check("rst_no_rsp", 64'(rsp_seen - snap), 64'd0);
        check("rst_idle",   64'({busy, wb_cyc}), 64'd0);

        // 2: write DR1 then read it back
        send(1'b1, 32'h08, 32'd20, 4'hF, '{err: 1'b0, tmo: 1'b0, dat: 32'd0},  w);
        send(1'b0, 32'h08, 32'd0,  4'hF, '{err: 1'b0, tmo: 1'b0, dat: 32'd20}, w);
        wait_idle("t2_idle");

        // 3: six back-to-back writes, zero-wait slave
        snap = cyc_rises;
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 32'(i * 4), tbl[i], 4'hF, '{err: 1'b0, tmo: 1'b0, dat: 32'd0}, w);
            check("t3_ready_wait", 64'(w), 64'd0);
        end
        wait_idle("t3_idle");
        check("t3_cyc_span", 64'(cyc_rises - snap), 64'd1);

        // 4: second request stalled for five cycles, partial byte write
        hold_adr = 32'h20;
        hold_dat = 32'h0000_5500;
        stall_at = ret_total + 1;
        send(1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF,    '{err: 1'b0, tmo: 1'b0, dat: 32'd0}, w);
        send(1'b1, 32'h20, 32'h0000_5500, 4'b0010, '{err: 1'b0, tmo: 1'b0, dat: 32'd0}, w);
        send(1'b0, 32'h20, 32'd0,         4'hF,    '{err: 1'b0, tmo: 1'b0, dat: 32'hDEAD_55EF}, w);
        wait_idle("t4_idle");
        check("t4_stall_cycles", 64'(st_cnt), 64'd5);

        // 5: acks withheld, three reads outstanding, timeout abort
        withhold = 1'b1;
        for (int i = 0; i < 3; i++)
            send(1'b0, 32'(i * 4), 32'd0, 4'hF, '{err: 1'b1, tmo: 1'b1, dat: 32'd0}, w);
        n = 0;
        while (n < 100) begin
            @(negedge clk_sys);
            if (!wb_cyc) break;
            n++;
        end
        check("t5_cyc_hold_cycles", 64'(n), 64'(TMO + 1));
        check("t5_ready_drain0", 64'(cmd_ready), 64'd0);
        @(negedge clk_sys);
        check("t5_ready_drain1", 64'(cmd_ready), 64'd0);
        @(negedge clk_sys);
        check("t5_ready_drain2", 64'(cmd_ready), 64'd0);
        @(posedge clk_sys); #1;
        wait_idle("t5_idle");
        withhold = 1'b0;

        // 6: error on the second of three reads, then a stray ack while idle
        err_at = ret_total + 1;
        send(1'b0, 32'h00, 32'd0, 4'hF, '{err: 1'b0, tmo: 1'b0, dat: 32'h0000_1001}, w);
        send(1'b0, 32'h04, 32'd0, 4'hF, '{err: 1'b1, tmo: 1'b0, dat: 32'd0}, w);
        send(1'b0, 32'h08, 32'd0, 4'hF, '{err: 1'b0, tmo: 1'b0, dat: 32'h0000_3003}, w);
        wait_idle("t6_idle");
        snap = rsp_seen;
        stray_req = stray_req + 1;
        repeat (5) @(posedge clk_sys);
        #1;
        check("t6_stray_no_rsp", 64'(rsp_seen - snap), 64'd0);
        check("t6_stray_idle",   64'({busy, wb_cyc}), 64'd0);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got still running, required finished");
        $fatal(1);
    end

endmodule
